// File: rtl/median_window_gen.sv
// median_window_gen: turns a raster pixel stream into 3x3 neighbourhood windows for the median sorter.
// Two line buffers supply the upper rows; a 3x3 shift array assembles each window.
module median_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int SIZE       = 8,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    input  logic                pix_sof,
    input  logic [SIZE-1:0]     pix_in,
    output logic                win_valid,
    output logic                win_last,
    output logic [9*SIZE-1:0]   window,
    output logic [COL_W-1:0]    ctr_col,
    output logic [ROW_W-1:0]    ctr_row
);
    localparam logic [COL_W-1:0] C_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [SIZE-1:0]   lb0_q [IMG_WIDTH];
    logic [SIZE-1:0]   lb1_q [IMG_WIDTH];
    logic [SIZE-1:0]   win_q [9];
    logic [SIZE-1:0]   win_d [9];
    logic [COL_W-1:0]  col_q, col_d, c;
    logic [ROW_W-1:0]  row_q, row_d, r;
    logic [SIZE-1:0]   top, mid;
    logic              hit, last;
    logic              valid_q, last_q;
    logic [9*SIZE-1:0] window_q;
    logic [COL_W-1:0]  ctr_col_q;
    logic [ROW_W-1:0]  ctr_row_q;

    // sof forces this pixel to be (0,0) whatever the counters say
    always_comb begin
        c     = pix_sof ? '0 : col_q;
        r     = pix_sof ? '0 : row_q;
        top   = lb1_q[c];
        mid   = lb0_q[c];
        col_d = (c == C_LAST) ? '0 : c + COL_W'(1);
        row_d = (c != C_LAST) ? r : (r == R_LAST) ? '0 : r + ROW_W'(1);
        hit   = pix_valid && r >= ROW_W'(2) && c >= COL_W'(2);
        last  = hit && r == R_LAST && c == C_LAST;
        for (int k = 0; k < 3; k++) begin
            win_d[3*k]   = win_q[3*k+1];
            win_d[3*k+1] = win_q[3*k+2];
        end
        win_d[2] = top;
        win_d[5] = mid;
        win_d[8] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            lb1_q[c] <= lb0_q[c];
            lb0_q[c] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            window_q  <= '0;
            ctr_col_q <= '0;
            ctr_row_q <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            valid_q <= hit;
            last_q  <= last;
            if (pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
            end
            if (hit) begin
                ctr_col_q <= c - COL_W'(1);
                ctr_row_q <= r - ROW_W'(1);
                for (int k = 0; k < 9; k++) window_q[k*SIZE +: SIZE] <= win_d[k];
            end
        end
    end

    assign win_valid = valid_q;
    assign win_last  = last_q;
    assign window    = window_q;
    assign ctr_col   = ctr_col_q;
    assign ctr_row   = ctr_row_q;
endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: directed checks of the 3x3 window generator on a 5x4 frame.
module tb_median_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        win_valid, win_last;
    logic [71:0] window;
    logic [2:0]  ctr_col;
    logic [1:0]  ctr_row;

    int          checks = 0;
    int          errors = 0;
    int          wins, lasts;
    logic [71:0] exp_win = '0;
    int          exp_cc = 0;
    int          exp_cr = 0;

    median_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SIZE(8), .COL_W(3), .ROW_W(2)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
        .win_valid(win_valid), .win_last(win_last), .window(window),
        .ctr_col(ctr_col), .ctr_row(ctr_row)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // window for centre (cr,cc) of a frame whose pixels are b + 16*row + col
    function automatic logic [71:0] ewin(input logic [7:0] b, input int cr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cq = 0; cq < 3; cq++)
                w[(3*rr+cq)*8 +: 8] = b + 8'(16*(cr-1+rr) + (cc-1+cq));
        return w;
    endfunction

    task automatic check_hold(input string tag);
        chk({tag, "_valid"}, 72'(win_valid), 72'(0));
        chk({tag, "_last"}, 72'(win_last), 72'(0));
        chk({tag, "_window"}, window, exp_win);
        chk({tag, "_ctr_col"}, 72'(ctr_col), 72'(exp_cc));
        chk({tag, "_ctr_row"}, 72'(ctr_row), 72'(exp_cr));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_hold("gap");
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit gaps, input int npix, input bit sof);
        int n;
        bit v, l;
        n = 0;
        wins = 0;
        lasts = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < npix) begin
                    pix_valid = 1'b1;
                    pix_sof   = sof && n == 0;
                    pix_in    = b + 8'(16*r + c);
                    @(posedge clk);
                    #1;
                    pix_valid = 1'b0;
                    pix_sof   = 1'b0;
                    v = r >= 2 && c >= 2;
                    l = v && r == H-1 && c == W-1;
                    if (v) begin
                        exp_win = ewin(b, r-1, c-1);
                        exp_cc  = c-1;
                        exp_cr  = r-1;
                    end
                    chk("win_valid", 72'(win_valid), 72'(v));
                    chk("win_last", 72'(win_last), 72'(l));
                    chk("window", window, exp_win);
                    chk("ctr_col", 72'(ctr_col), 72'(exp_cc));
                    chk("ctr_row", 72'(ctr_row), 72'(exp_cr));
                    wins  += int'(win_valid);
                    lasts += int'(win_last);
                    if (gaps) idle(int'($urandom_range(1, 3)));
                    n++;
                end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_hold("reset");
        rst = 1'b0;
        pix_sof = 1'b1;
        @(posedge clk);
        #1;
        pix_sof = 1'b0;
        check_hold("sof_no_valid");

        frame(8'h00, 1'b0, W*H, 1'b1);
        chk("basic_nwin", 72'(wins), 72'(6));
        chk("basic_nlast", 72'(lasts), 72'(1));
        chk("basic_i8", 72'(window[71:64]), 72'(8'h34));

        frame(8'h00, 1'b1, W*H, 1'b1);
        chk("gaps_nwin", 72'(wins), 72'(6));
        chk("gaps_nlast", 72'(lasts), 72'(1));

        frame(8'h00, 1'b0, W*H, 1'b1);
        frame(8'h80, 1'b0, W*H, 1'b1);
        chk("f2_nwin", 72'(wins), 72'(6));
        chk("f2_nlast", 72'(lasts), 72'(1));
        chk("f2_i4", 72'(window[39:32]), 72'(8'hA3));

        frame(8'h00, 1'b0, 2*W+1, 1'b1);
        chk("trunc_nwin", 72'(wins), 72'(0));
        chk("trunc_nlast", 72'(lasts), 72'(0));
        frame(8'h40, 1'b0, W*H, 1'b1);
        chk("resync_nwin", 72'(wins), 72'(6));
        chk("resync_nlast", 72'(lasts), 72'(1));

        frame(8'h00, 1'b0, 2*W+3, 1'b1);
        chk("pre_rst_nwin", 72'(wins), 72'(1));
        rst = 1'b1;
        pix_valid = 1'b1;
        pix_in = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        exp_win = '0;
        exp_cc = 0;
        exp_cr = 0;
        check_hold("mid_rst");
        frame(8'h20, 1'b1, W*H, 1'b0);
        chk("rst_nwin", 72'(wins), 72'(6));
        chk("rst_nlast", 72'(lasts), 72'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
